// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: size codes, FSM states,
// and the natural-alignment check.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmemState;

  function automatic logic isAligned(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (sz == SZ_BYTE): ok = 1'b1;
      (sz == SZ_HALF): ok = ~lo[0];
      (sz == SZ_WORD): ok = (lo == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_extend.sv
// Big-endian lane select with sign/zero extension for
// byte and halfword reads.
module dmem_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        signExt,
  output logic [31:0] result
);

  logic [7:0]  bSel;
  logic [15:0] hSel;

  always_comb begin
    bSel = word[7:0];
    unique case (lo)
      2'd0:    bSel = word[31:24];
      2'd1:    bSel = word[23:16];
      2'd2:    bSel = word[15:8];
      default: bSel = word[7:0];
    endcase
    hSel = lo[1] ? word[15:0] : word[31:16];
    result = word;
    unique case (1'b1)
      (size == SZ_BYTE):
        result = {{24{signExt & bSel[7]}}, bSel};
      (size == SZ_HALF):
        result = {{16{signExt & hSel[15]}}, hSel};
      default:
        result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed big-endian data memory with wait states and fault flag.
// Define DMEM_RANGE_CHECK_EN to fault accesses past DEPTH_BYTES.
module data_mem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WLOAD =
    4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  logic [7:0] mem [DEPTH_BYTES];

  dmemState state, nextState;
  logic [3:0] cnt, cntNext;

  logic          weQ, sxQ, faultQ;
  logic [1:0]    sizeQ;
  logic [AW-1:0] addrQ;
  logic [31:0]   dataQ;

  logic          inFault, rangeFault;
  logic          accepting, goDone;
  logic          curWe, curSx, curFault;
  logic [1:0]    curSize;
  logic [AW-1:0] curAddr;
  logic [31:0]   curData;
  logic [AW-3:0] base;
  logic [31:0]   rdWord, rdExt;

`ifdef DMEM_RANGE_CHECK_EN
  logic [1:0]  spanM1;
  logic [32:0] lastByte;
  assign spanM1 = {size[1], size[1] | size[0]};
  assign lastByte = {1'b0, DAddr} + 33'(spanM1);
  assign rangeFault = lastByte >= 33'(DEPTH_BYTES);
`else
  // Upper address bits alias onto the array.
  logic unusedHighAddr;
  assign unusedHighAddr = ^DAddr[31:AW];
  assign rangeFault = 1'b0;
`endif

  assign inFault = ~isAligned(size, DAddr[1:0]) | rangeFault;

  // In IDLE the access resolves from the live inputs so a
  // zero-wait access completes on its acceptance edge.
  assign accepting = (state == IDLE);
  assign curWe     = accepting ? we : weQ;
  assign curSx     = accepting ? sign_ext : sxQ;
  assign curSize   = accepting ? size : sizeQ;
  assign curAddr   = accepting ? DAddr[AW-1:0] : addrQ;
  assign curData   = accepting ? DataIn : dataQ;
  assign curFault  = accepting ? inFault : faultQ;

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (inFault || WAIT_CYCLES == 0) begin
            nextState = DONE;
          end else begin
            nextState = WAIT;
            cntNext   = WLOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) nextState = DONE;
        else cntNext = cnt - 4'd1;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign goDone = (nextState == DONE) && (state != DONE);

  assign base = curAddr[AW-1:2];
  assign rdWord = {mem[{base, 2'b00}], mem[{base, 2'b01}],
                   mem[{base, 2'b10}], mem[{base, 2'b11}]};

  dmem_extend uExt (
    .word    (rdWord),
    .lo      (curAddr[1:0]),
    .size    (curSize),
    .signExt (curSx),
    .result  (rdExt)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      DataOut <= '0;
      err     <= 1'b0;
      weQ     <= 1'b0;
      sxQ     <= 1'b0;
      faultQ  <= 1'b0;
      sizeQ   <= SZ_BYTE;
      addrQ   <= '0;
      dataQ   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      err   <= goDone & curFault;
      DataOut <= (goDone && !curWe && !curFault) ? rdExt : '0;
      if (accepting && req) begin
        weQ    <= we;
        sxQ    <= sign_ext;
        faultQ <= inFault;
        sizeQ  <= size;
        addrQ  <= DAddr[AW-1:0];
        dataQ  <= DataIn;
      end
    end
  end

  // Storage is not reset; a reset mid-access suppresses the write.
  always_ff @(posedge CLK) begin
    if (!Reset && goDone && curWe && !curFault) begin
      unique case (1'b1)
        (curSize == SZ_BYTE): begin
          mem[curAddr] <= curData[7:0];
        end
        (curSize == SZ_HALF): begin
          mem[{curAddr[AW-1:1], 1'b0}] <= curData[15:8];
          mem[{curAddr[AW-1:1], 1'b1}] <= curData[7:0];
        end
        default: begin
          mem[{base, 2'b00}] <= curData[31:24];
          mem[{base, 2'b01}] <= curData[23:16];
          mem[{base, 2'b10}] <= curData[15:8];
          mem[{base, 2'b11}] <= curData[7:0];
        end
      endcase
    end
  end

  assign ready = (state == DONE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench for data_mem_sized: directed accesses push
// expected responses, a negedge monitor checks each ready pulse.
module tb_data_mem_sized;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WC    = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = SZ_WORD;
  logic        sign_ext = 1'b0;
  logic [31:0] DAddr = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        ready, busy, err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        e;
    int          at;
    string       name;
  } expT;

  expT expQ[$];

  data_mem_sized #(
    .DEPTH_BYTES (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .DAddr    (DAddr),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .ready    (ready),
    .busy     (busy),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    expT it;
    if (ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready at cyc %0d want none",
                 cyc);
      end else begin
        it = expQ.pop_front();
        check({it.name, "_data"}, DataOut, it.data);
        check({it.name, "_err"}, 32'(err), 32'(it.e));
        check({it.name, "_cyc"}, 32'(cyc), 32'(it.at));
        check({it.name, "_busy"}, 32'(busy), 32'd1);
      end
    end else if (!Reset) begin
      if (err !== 1'b0 || DataOut !== '0) begin
        total++;
        bad++;
        $display("FAIL idle_zero: got err=%b data=%h want 0/0",
                 err, DataOut);
      end
    end
  end

  task automatic access(input string name, input logic w,
                        input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expD, input logic expE);
    int lat;
    int n;
    expT it;
    @(negedge CLK);
    we = w;
    size = sz;
    sign_ext = sx;
    DAddr = a;
    DataIn = d;
    req = 1'b1;
    lat = expE ? 0 : WC;
    it.data = expD;
    it.e = expE;
    it.at = cyc + 1 + lat;
    it.name = name;
    expQ.push_back(it);
    @(negedge CLK);
    req = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready want ready", name);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    int c0;
    expT it;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dout", DataOut, 32'd0);
    Reset = 1'b0;

    access("sw10", 1, SZ_WORD, 0, 32'h10, 32'h11223344, 0, 0);
    access("lbu10", 0, SZ_BYTE, 0, 32'h10, 0, 32'h11, 0);
    access("lbu11", 0, SZ_BYTE, 0, 32'h11, 0, 32'h22, 0);
    access("lbu12", 0, SZ_BYTE, 0, 32'h12, 0, 32'h33, 0);
    access("lbu13", 0, SZ_BYTE, 0, 32'h13, 0, 32'h44, 0);
    access("lh12", 0, SZ_HALF, 1, 32'h12, 0, 32'h00003344, 0);

    access("sw20", 1, SZ_WORD, 0, 32'h20, 32'hAABBCCDD, 0, 0);
    access("sb21", 1, SZ_BYTE, 0, 32'h21, 32'h00000080, 0, 0);
    access("lb21", 0, SZ_BYTE, 1, 32'h21, 0, 32'hFFFFFF80, 0);
    access("lbu21", 0, SZ_BYTE, 0, 32'h21, 0, 32'h00000080, 0);
    access("lw20a", 0, SZ_WORD, 0, 32'h20, 0, 32'hAA80CCDD, 0);
    access("sh22", 1, SZ_HALF, 0, 32'h22, 32'h00008001, 0, 0);
    access("lh22", 0, SZ_HALF, 1, 32'h22, 0, 32'hFFFF8001, 0);
    access("lhu22", 0, SZ_HALF, 0, 32'h22, 0, 32'h00008001, 0);
    access("lh20", 0, SZ_HALF, 1, 32'h20, 0, 32'hFFFFAA80, 0);
    access("lw20b", 0, SZ_WORD, 0, 32'h20, 0, 32'hAA808001, 0);

    access("lh13", 0, SZ_HALF, 1, 32'h13, 0, 0, 1);
    access("sw12", 1, SZ_WORD, 0, 32'h12, 32'hFFFFFFFF, 0, 1);
    access("sz11", 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 0, 1);
    access("sh11", 1, SZ_HALF, 0, 32'h11, 32'h0000FFFF, 0, 1);
    access("lw10", 0, SZ_WORD, 0, 32'h10, 0, 32'h11223344, 0);

    access("sw40", 1, SZ_WORD, 0, 32'h40, 32'hA5A55A5A, 0, 0);
    @(negedge CLK);
    we = 1'b1;
    size = SZ_WORD;
    DAddr = 32'h40;
    DataIn = 32'hDEADBEEF;
    req = 1'b1;
    @(negedge CLK);
    check("abort_busy_wait", 32'(busy), 32'd1);
    req = 1'b0;
    Reset = 1'b1;
    @(negedge CLK);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    Reset = 1'b0;
    access("lw40", 0, SZ_WORD, 0, 32'h40, 0, 32'hA5A55A5A, 0);

    @(negedge CLK);
    we = 1'b0;
    size = SZ_WORD;
    sign_ext = 1'b0;
    DAddr = 32'h10;
    req = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      it.data = 32'h11223344;
      it.e = 1'b0;
      it.at = c0 + 1 + WC + k * (WC + 2);
      it.name = "b2b";
      expQ.push_back(it);
    end
    repeat (1 + 2 * (WC + 2)) @(negedge CLK);
    req = 1'b0;
    drain();

`ifdef DMEM_RANGE_CHECK_EN
    access("lw3fe", 0, SZ_WORD, 0, 32'h3FE, 0, 0, 1);
    access("sw400", 1, SZ_WORD, 0, 32'h400, 32'hCAFEF00D, 0, 1);
    access("lw000", 0, SZ_WORD, 0, 32'h10, 0, 32'h11223344, 0);
`else
    access("sw400", 1, SZ_WORD, 0, 32'h400, 32'hCAFEF00D, 0, 0);
    access("lw000", 0, SZ_WORD, 0, 32'h000, 0, 32'hCAFEF00D, 0);
`endif

    drain();
    repeat (4) @(negedge CLK);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
